// File: rtl/pht_pkg.sv
// Shared types and constants for the PHT write scheduler.
package pht_pkg;

  typedef enum logic {
    SWEEP = 1'b0,
    RUN   = 1'b1
  } pht_state_e;

  localparam int unsigned DROP_CNT_WIDTH = 8;

  function automatic logic [DROP_CNT_WIDTH-1:0] sat_inc(input logic [DROP_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pht_write_scheduler_if.sv
// Request/write-port bundle of the PHT write scheduler.
// Optional forwarding signals exist only when PHT_WR_FORWARD_EN is defined.
interface pht_write_scheduler_if #(
  parameter int unsigned INDEX_WIDTH   = 12,
  parameter int unsigned COUNTER_WIDTH = 2
);
  logic                               flush_req;
  logic                               rb_valid;
  logic [INDEX_WIDTH-1:0]             rb_index;
  logic [COUNTER_WIDTH-1:0]           rb_data;
  logic                               co_valid;
  logic [INDEX_WIDTH-1:0]             co_index;
  logic [COUNTER_WIDTH-1:0]           co_data;
  logic                               wr_en;
  logic [INDEX_WIDTH-1:0]             wr_index;
  logic [COUNTER_WIDTH-1:0]           wr_data;
  logic                               busy;
  logic                               buf_full;
  logic [pht_pkg::DROP_CNT_WIDTH-1:0] drop_cnt;
`ifdef PHT_WR_FORWARD_EN
  logic [INDEX_WIDTH-1:0]             rd_index;
  logic                               fwd_hit;
  logic [COUNTER_WIDTH-1:0]           fwd_data;
`endif

  modport master (
    output flush_req, rb_valid, rb_index, rb_data, co_valid, co_index, co_data,
    input  wr_en, wr_index, wr_data, busy, buf_full, drop_cnt
`ifdef PHT_WR_FORWARD_EN
    , output rd_index,
    input  fwd_hit, fwd_data
`endif
  );

  modport slave (
    input  flush_req, rb_valid, rb_index, rb_data, co_valid, co_index, co_data,
    output wr_en, wr_index, wr_data, busy, buf_full, drop_cnt
`ifdef PHT_WR_FORWARD_EN
    , input rd_index,
    output fwd_hit, fwd_data
`endif
  );

endinterface

// File: rtl/pht_wbuf.sv
// Coalescing write buffer for deferred corrected PHT writes.
// PHT_WR_FORWARD_EN adds a combinational slot lookup on i_rd_index.
module pht_wbuf #(
  parameter int unsigned INDEX_WIDTH   = 12,
  parameter int unsigned COUNTER_WIDTH = 2,
  parameter int unsigned BUF_DEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_clear,
  input  logic                     i_rb_inval,
  input  logic [INDEX_WIDTH-1:0]   i_rb_index,
  input  logic                     i_drain,
  input  logic                     i_co_push,
  input  logic [INDEX_WIDTH-1:0]   i_co_index,
  input  logic [COUNTER_WIDTH-1:0] i_co_data,
  output logic                     o_drain_valid,
  output logic [INDEX_WIDTH-1:0]   o_drain_index,
  output logic [COUNTER_WIDTH-1:0] o_drain_data,
  output logic                     o_full,
  output logic                     o_co_drop
`ifdef PHT_WR_FORWARD_EN
  ,
  input  logic [INDEX_WIDTH-1:0]   i_rd_index,
  output logic                     o_fwd_hit,
  output logic [COUNTER_WIDTH-1:0] o_fwd_data
`endif
);

  localparam int unsigned SEL_W = $clog2(BUF_DEPTH);

  typedef struct packed {
    logic                     valid;
    logic [INDEX_WIDTH-1:0]   index;
    logic [COUNTER_WIDTH-1:0] data;
  } slot_t;

  slot_t                r_slot [BUF_DEPTH];
  logic [BUF_DEPTH-1:0] w_valid;
  logic [BUF_DEPTH-1:0] w_inval;
  logic [BUF_DEPTH-1:0] w_drained;
  logic [BUF_DEPTH-1:0] w_live;
  logic [SEL_W-1:0]     w_drain_sel;
  logic [SEL_W-1:0]     w_match_sel;
  logic [SEL_W-1:0]     w_free_sel;
  logic                 w_has_valid;
  logic                 w_match_found;
  logic                 w_free_found;

  // Free slots come from the pre-cycle valid bits, so a slot released this
  // cycle is never reused; matches exclude slots invalidated or drained now.
  always_comb begin
    w_valid       = '0;
    w_inval       = '0;
    w_drained     = '0;
    w_live        = '0;
    w_drain_sel   = '0;
    w_match_sel   = '0;
    w_free_sel    = '0;
    w_has_valid   = 1'b0;
    w_match_found = 1'b0;
    w_free_found  = 1'b0;
    for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
      w_valid[i] = r_slot[i].valid;
      if (w_valid[i] && !w_has_valid) begin
        w_has_valid = 1'b1;
        w_drain_sel = SEL_W'(i);
      end
      if (!w_valid[i] && !w_free_found) begin
        w_free_found = 1'b1;
        w_free_sel   = SEL_W'(i);
      end
    end
    for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
      w_inval[i]   = i_rb_inval && w_valid[i] && (r_slot[i].index == i_rb_index);
      w_drained[i] = i_drain && w_has_valid && (w_drain_sel == SEL_W'(i));
      w_live[i]    = w_valid[i] && !w_inval[i] && !w_drained[i];
      if (w_live[i] && (r_slot[i].index == i_co_index) && !w_match_found) begin
        w_match_found = 1'b1;
        w_match_sel   = SEL_W'(i);
      end
    end
  end

  assign o_drain_valid = w_has_valid;
  assign o_drain_index = r_slot[w_drain_sel].index;
  assign o_drain_data  = r_slot[w_drain_sel].data;
  assign o_full        = &w_valid;
  assign o_co_drop     = i_co_push && !w_match_found && !w_free_found;

  always_ff @(posedge clk) begin
    if (!rst_n || i_clear) begin
      for (int unsigned i = 0; i < BUF_DEPTH; i++) r_slot[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
        if (w_inval[i] || w_drained[i]) r_slot[i].valid <= 1'b0;
        if (i_co_push && w_match_found && (w_match_sel == SEL_W'(i)))
          r_slot[i].data <= i_co_data;
        if (i_co_push && !w_match_found && w_free_found && (w_free_sel == SEL_W'(i)))
          r_slot[i] <= '{valid: 1'b1, index: i_co_index, data: i_co_data};
      end
    end
  end

`ifdef PHT_WR_FORWARD_EN
  always_comb begin
    o_fwd_hit  = 1'b0;
    o_fwd_data = '0;
    for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
      if (w_valid[i] && (r_slot[i].index == i_rd_index) && !o_fwd_hit) begin
        o_fwd_hit  = 1'b1;
        o_fwd_data = r_slot[i].data;
      end
    end
  end
`endif

endmodule

// File: rtl/pht_write_scheduler.sv
// Single registered PHT write port: init sweep, rollback priority, buffered corrected writes.
// Define PHT_WR_FORWARD_EN to add read-index forwarding from the write stage and buffer.
module pht_write_scheduler
  import pht_pkg::*;
#(
  parameter int unsigned              INDEX_WIDTH   = 12,
  parameter int unsigned              COUNTER_WIDTH = 2,
  parameter logic [COUNTER_WIDTH-1:0] COUNTER_INIT  = '0,
  parameter int unsigned              BUF_DEPTH     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pht_write_scheduler_if.slave  bus
);

  pht_state_e                r_state;
  logic [INDEX_WIDTH-1:0]    r_sweep_cnt;
  logic                      r_wr_en;
  logic [INDEX_WIDTH-1:0]    r_wr_index;
  logic [COUNTER_WIDTH-1:0]  r_wr_data;
  logic [DROP_CNT_WIDTH-1:0] r_drop_cnt;

  logic                      w_run;
  logic                      w_rb_go;
  logic                      w_drain_go;
  logic                      w_co_direct;
  logic                      w_co_push;
  logic                      w_drain_valid;
  logic [INDEX_WIDTH-1:0]    w_drain_index;
  logic [COUNTER_WIDTH-1:0]  w_drain_data;
  logic                      w_full;
  logic                      w_co_drop;

  assign w_run       = (r_state == RUN) && !bus.flush_req;
  assign w_rb_go     = w_run && bus.rb_valid;
  assign w_drain_go  = w_run && !bus.rb_valid && w_drain_valid;
  assign w_co_direct = w_run && !bus.rb_valid && !w_drain_valid && bus.co_valid;
  assign w_co_push   = w_run && bus.co_valid && !w_co_direct;

`ifdef PHT_WR_FORWARD_EN
  logic                     w_slot_hit;
  logic [COUNTER_WIDTH-1:0] w_slot_data;
  logic                     w_wr_hit;
  logic                     w_fwd_on;
`endif

  pht_wbuf #(
    .INDEX_WIDTH   (INDEX_WIDTH),
    .COUNTER_WIDTH (COUNTER_WIDTH),
    .BUF_DEPTH     (BUF_DEPTH)
  ) u_wbuf (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_clear       (bus.flush_req),
    .i_rb_inval    (w_rb_go),
    .i_rb_index    (bus.rb_index),
    .i_drain       (w_drain_go),
    .i_co_push     (w_co_push),
    .i_co_index    (bus.co_index),
    .i_co_data     (bus.co_data),
    .o_drain_valid (w_drain_valid),
    .o_drain_index (w_drain_index),
    .o_drain_data  (w_drain_data),
    .o_full        (w_full),
    .o_co_drop     (w_co_drop)
`ifdef PHT_WR_FORWARD_EN
    ,
    .i_rd_index    (bus.rd_index),
    .o_fwd_hit     (w_slot_hit),
    .o_fwd_data    (w_slot_data)
`endif
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= SWEEP;
      r_sweep_cnt <= '0;
      r_wr_en     <= 1'b0;
      r_wr_index  <= '0;
      r_wr_data   <= '0;
      r_drop_cnt  <= '0;
    end else if (bus.flush_req) begin
      r_state     <= SWEEP;
      r_sweep_cnt <= '0;
      r_wr_en     <= 1'b0;
    end else begin
      unique case (r_state)
        SWEEP: begin
          r_wr_en     <= 1'b1;
          r_wr_index  <= r_sweep_cnt;
          r_wr_data   <= COUNTER_INIT;
          r_sweep_cnt <= r_sweep_cnt + 1'b1;
          if (&r_sweep_cnt) r_state <= RUN;
        end
        RUN: begin
          if (w_rb_go) begin
            r_wr_en    <= 1'b1;
            r_wr_index <= bus.rb_index;
            r_wr_data  <= bus.rb_data;
          end else if (w_drain_go) begin
            r_wr_en    <= 1'b1;
            r_wr_index <= w_drain_index;
            r_wr_data  <= w_drain_data;
          end else if (w_co_direct) begin
            r_wr_en    <= 1'b1;
            r_wr_index <= bus.co_index;
            r_wr_data  <= bus.co_data;
          end else begin
            r_wr_en    <= 1'b0;
          end
          if (w_co_drop) r_drop_cnt <= sat_inc(r_drop_cnt);
        end
      endcase
    end
  end

  assign bus.wr_en    = r_wr_en;
  assign bus.wr_index = r_wr_index;
  assign bus.wr_data  = r_wr_data;
  assign bus.busy     = (r_state == SWEEP);
  assign bus.buf_full = w_full;
  assign bus.drop_cnt = r_drop_cnt;

`ifdef PHT_WR_FORWARD_EN
  // The write stage is newer than any buffered value, so it wins on a match.
  assign w_fwd_on     = (r_state == RUN);
  assign w_wr_hit     = r_wr_en && (r_wr_index == bus.rd_index);
  assign bus.fwd_hit  = w_fwd_on && (w_wr_hit || w_slot_hit);
  assign bus.fwd_data = !w_fwd_on ? '0 :
                        w_wr_hit  ? r_wr_data :
                        w_slot_hit ? w_slot_data : '0;
`endif

endmodule

// File: tb/tb_pht_write_scheduler.sv
// Self-checking bench for pht_write_scheduler (INDEX_WIDTH=4, COUNTER_INIT=1, BUF_DEPTH=4).
module tb_pht_write_scheduler;

  localparam int IW    = 4;
  localparam int CW    = 2;
  localparam int DEPTH = 4;
  localparam int NENT  = 16;
  localparam int INIT  = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pht_write_scheduler_if #(.INDEX_WIDTH(IW), .COUNTER_WIDTH(CW)) bus();

  pht_write_scheduler #(
    .INDEX_WIDTH   (IW),
    .COUNTER_WIDTH (CW),
    .COUNTER_INIT  (2'd1),
    .BUF_DEPTH     (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct { int idx; int dat; bit busy; } wrec_t;
  wrec_t wlog[$];

  // Reference model: sweep position, pending corrected writes per slot, expected outputs.
  bit m_sweep;
  int m_cnt;
  bit m_wr_en;
  int m_wr_idx, m_wr_dat, m_drop;
  bit m_v[DEPTH];
  int m_i[DEPTH], m_d[DEPTH];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic issue(input int idx, input int dat);
    m_wr_en  = 1'b1;
    m_wr_idx = idx;
    m_wr_dat = dat;
  endtask

  task automatic model_step();
    bit ov[DEPTH];
    bit direct;
    int k;
    direct = 1'b0;
    if (!rst_n) begin
      m_sweep = 1; m_cnt = 0; m_wr_en = 0; m_wr_idx = 0; m_wr_dat = 0; m_drop = 0;
      for (int i = 0; i < DEPTH; i++) m_v[i] = 0;
    end else if (bus.flush_req) begin
      m_sweep = 1; m_cnt = 0; m_wr_en = 0;
      for (int i = 0; i < DEPTH; i++) m_v[i] = 0;
    end else if (m_sweep) begin
      issue(m_cnt, INIT);
      m_cnt++;
      if (m_cnt == NENT) m_sweep = 0;
    end else begin
      ov = m_v;
      if (bus.rb_valid) begin
        issue(int'(bus.rb_index), int'(bus.rb_data));
        for (int i = 0; i < DEPTH; i++)
          if (ov[i] && m_i[i] == int'(bus.rb_index)) m_v[i] = 0;
      end else begin
        k = -1;
        for (int i = 0; i < DEPTH; i++) if (ov[i] && k < 0) k = i;
        if (k >= 0) begin
          issue(m_i[k], m_d[k]);
          m_v[k] = 0;
        end else if (bus.co_valid) begin
          issue(int'(bus.co_index), int'(bus.co_data));
          direct = 1;
        end else begin
          m_wr_en = 0;
        end
      end
      if (bus.co_valid && !direct) begin
        k = -1;
        for (int i = 0; i < DEPTH; i++) if (m_v[i] && m_i[i] == int'(bus.co_index)) k = i;
        if (k >= 0) m_d[k] = int'(bus.co_data);
        else begin
          for (int i = 0; i < DEPTH; i++) if (!ov[i] && k < 0) k = i;
          if (k >= 0) begin
            m_v[k] = 1; m_i[k] = int'(bus.co_index); m_d[k] = int'(bus.co_data);
          end else if (m_drop < 255) m_drop++;
        end
      end
    end
  endtask

  // Single compare process: model advances on the edge, outputs checked 1 time unit later.
  initial begin
    bit full;
    forever begin
      @(posedge clk);
      model_step();
      #1;
      full = 1;
      for (int i = 0; i < DEPTH; i++) if (!m_v[i]) full = 0;
      chk("wr_en",    int'(bus.wr_en),    int'(m_wr_en));
      chk("wr_index", int'(bus.wr_index), m_wr_idx);
      chk("wr_data",  int'(bus.wr_data),  m_wr_dat);
      chk("busy",     int'(bus.busy),     int'(m_sweep));
      chk("buf_full", int'(bus.buf_full), int'(full));
      chk("drop_cnt", int'(bus.drop_cnt), m_drop);
      if (bus.wr_en === 1'b1)
        wlog.push_back('{idx: int'(bus.wr_index), dat: int'(bus.wr_data), busy: bus.busy});
    end
  end

  task automatic drive(input bit rb, input int ri, input int rd,
                       input bit co, input int ci, input int cd, input bit fl);
    @(negedge clk);
    bus.rb_valid  = rb;
    bus.rb_index  = IW'(ri);
    bus.rb_data   = CW'(rd);
    bus.co_valid  = co;
    bus.co_index  = IW'(ci);
    bus.co_data   = CW'(cd);
    bus.flush_req = fl;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk(name, int'(bus.busy), 0);
  endtask

  task automatic expect_w(input string nm, input int pos, input int idx, input int dat);
    if (pos < wlog.size()) begin
      chk({nm, "_idx"}, wlog[pos].idx, idx);
      chk({nm, "_dat"}, wlog[pos].dat, dat);
    end else begin
      chk({nm, "_missing"}, wlog.size(), pos + 1);
    end
  endtask

  task automatic expect_sweep(input string nm);
    chk({nm, "_count"}, wlog.size(), NENT);
    for (int i = 0; i < NENT; i++) expect_w($sformatf("%s%0d", nm, i), i, i, INIT);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.flush_req = 0; bus.rb_valid = 0; bus.rb_index = '0; bus.rb_data = '0;
    bus.co_valid = 0; bus.co_index = '0; bus.co_data = '0;
`ifdef PHT_WR_FORWARD_EN
    bus.rd_index = '0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_busy",     int'(bus.busy), 1);
    chk("rst_wr_en",    int'(bus.wr_en), 0);
    chk("rst_buf_full", int'(bus.buf_full), 0);
    chk("rst_drop",     int'(bus.drop_cnt), 0);
    rst_n = 1'b1;

    // Power-on sweep
    idle(1);
    wait_idle("sweep_done");
    idle(2);
    expect_sweep("sweep");
    if (wlog.size() == NENT) begin
      chk("sweep_busy_first", int'(wlog[0].busy), 1);
      chk("sweep_busy_14",    int'(wlog[14].busy), 1);
      chk("sweep_busy_last",  int'(wlog[15].busy), 0);
    end

    // Rollback first, corrected from buffer next cycle
    wlog.delete();
    drive(1, 5, 3, 1, 9, 0, 0);
    idle(3);
    chk("rbco_count", wlog.size(), 2);
    expect_w("rbco_0", 0, 5, 3);
    expect_w("rbco_1", 1, 9, 0);

    // Same index in one cycle: corrected lands after rollback
    wlog.delete();
    drive(1, 6, 3, 1, 6, 1, 0);
    idle(3);
    chk("same_count", wlog.size(), 2);
    expect_w("same_0", 0, 6, 3);
    expect_w("same_1", 1, 6, 1);

    // Fill buffer under rollback pressure, drop the fifth, drain in slot order
    wlog.delete();
    for (int k = 1; k <= 5; k++) begin
      drive(1, k + 8, 2, 1, k, k % 4, 0);
      if (k == 5) chk("fill_buf_full", int'(bus.buf_full), 1);
    end
    idle(6);
    chk("fill_drop", int'(bus.drop_cnt), 1);
    chk("fill_count", wlog.size(), 9);
    for (int k = 0; k < 5; k++) expect_w($sformatf("fill_rb%0d", k), k, k + 9, 2);
    for (int k = 1; k <= 4; k++) expect_w($sformatf("fill_drain%0d", k), k + 4, k, k % 4);

    // Overwrite in place
    wlog.delete();
    drive(1, 12, 1, 1, 7, 2, 0);
    drive(1, 13, 1, 1, 7, 0, 0);
    idle(3);
    chk("ovr_count", wlog.size(), 3);
    expect_w("ovr_2", 2, 7, 0);

    // Rollback to a buffered index kills the stale entry
    wlog.delete();
    drive(1, 12, 1, 1, 7, 2, 0);
    drive(1, 7, 3, 0, 0, 0, 0);
    idle(3);
    chk("inval_count", wlog.size(), 2);
    expect_w("inval_0", 0, 12, 1);
    expect_w("inval_1", 1, 7, 3);

`ifdef PHT_WR_FORWARD_EN
    wlog.delete();
    drive(1, 3, 1, 1, 3, 2, 0);
    drive(1, 10, 1, 0, 0, 0, 0);
    bus.rd_index = 4'd3;
    #1;
    chk("fwd_wr_hit",  int'(bus.fwd_hit), 1);
    chk("fwd_wr_data", int'(bus.fwd_data), 1);
    drive(1, 11, 1, 0, 0, 0, 0);
    #1;
    chk("fwd_slot_hit",  int'(bus.fwd_hit), 1);
    chk("fwd_slot_data", int'(bus.fwd_data), 2);
    bus.rd_index = 4'd5;
    #1;
    chk("fwd_miss", int'(bus.fwd_hit), 0);
    idle(3);
    expect_w("fwd_drain", 3, 3, 2);
`endif

    // Drop counter saturation
    for (int k = 0; k < DEPTH; k++) drive(1, 12, 0, 1, k, 1, 0);
    repeat (256) drive(1, 12, 0, 1, 8, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("sat_drop", int'(bus.drop_cnt), 255);
    chk("sat_full", int'(bus.buf_full), 1);

    // Flush with full buffer, then flush again at sweep_cnt=8
    idle(1);
    chk("flush_empty", int'(bus.buf_full), 0);
    chk("flush_busy",  int'(bus.busy), 1);
    chk("flush_drop",  int'(bus.drop_cnt), 255);
    idle(7);
`ifdef PHT_WR_FORWARD_EN
    bus.rd_index = bus.wr_index;
    #1;
    chk("fwd_sweep_hit",  int'(bus.fwd_hit), 0);
    chk("fwd_sweep_data", int'(bus.fwd_data), 0);
`endif
    drive(0, 0, 0, 0, 0, 0, 1);
    wlog.delete();
    idle(1);
    wait_idle("reflush_done");
    idle(4);
    expect_sweep("reflush");

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pht_write_scheduler.md
Name: pht_write_scheduler

Overview:
- Sequences every write into the pattern history table (PHT) through one registered write port.
- Owns the power-on/flush initialisation sweep.
- Arbitrates between two update sources:
  - rollback updates from EX (high priority, never delayed);
  - branch-resolution "corrected" updates (low priority, buffered in a small coalescing write buffer).
- Sits between the history predictor's counter-update logic and the PHT storage.

Parameters:
- INDEX_WIDTH, 12, PHT index width; table has 2^INDEX_WIDTH entries.
- COUNTER_WIDTH, 2, saturating jump-status counter width.
- COUNTER_INIT, 0, value written to every entry during a sweep.
- BUF_DEPTH, 4, number of write-buffer slots for deferred corrected writes (2..8).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- flush_req  in  1  pulse; restarts the init sweep.
- rb_valid  in  1  rollback write request.
- rb_index  in  INDEX_WIDTH  rollback target index.
- rb_data  in  COUNTER_WIDTH  rollback counter value.
- co_valid  in  1  corrected write request.
- co_index  in  INDEX_WIDTH  corrected target index.
- co_data  in  COUNTER_WIDTH  corrected counter value.
- wr_en  out  1  PHT write enable (registered).
- wr_index  out  INDEX_WIDTH  PHT write index (registered).
- wr_data  out  COUNTER_WIDTH  PHT write data (registered).
- busy  out  1  sweep in progress; pipeline must stall predictor updates.
- buf_full  out  1  all buffer slots valid.
- drop_cnt  out  8  saturating count of dropped corrected writes.

Behaviour:
- State machine, two states: SWEEP and RUN.
  - Reset enters SWEEP with sweep_cnt=0.
  - Also on reset: wr_en=0, wr_index=0, wr_data=0, buffer all invalid, drop_cnt=0, busy=1, buf_full=0.
- SWEEP:
  - Each cycle issue write {index=sweep_cnt, data=COUNTER_INIT}; sweep_cnt++.
  - After index 2^INDEX_WIDTH-1 is issued, go to RUN the next cycle; busy deasserts in that same cycle.
  - rb/co requests are ignored and not counted in drop_cnt.
- flush_req, in any state:
  - next state SWEEP, sweep_cnt=0, all buffer slots invalidated.
  - A flush mid-sweep restarts the sweep from 0.
- RUN arbitration (one write per cycle; the issue decision made in cycle N appears on wr_* in cycle N+1):
  - 1. rb_valid: issue rollback. Any buffer slot whose index equals rb_index is invalidated the same cycle.
  - 2. Else a buffer slot is valid: issue the lowest-numbered valid slot and free it.
  - 3. Else co_valid: issue corrected directly (bypasses the buffer).
- Corrected request not issued directly:
  - co_index matches a valid slot: overwrite that slot's data in place.
  - Else allocate the lowest free slot.
  - Else (full): drop the request; drop_cnt++ (saturates at 255).
- co_index == rb_index in the same cycle: rollback is issued, corrected is buffered normally. Rollback data is never lost; the corrected value lands later and wins.
- Coalescing order in one cycle: invalidate on rb match first, then allocate/overwrite for co. A slot freed this cycle by drain or invalidate is not reusable until the next cycle.
- buf_full is combinational from the slot valid bits.
- Nothing arrives with wr_en=0 except idle cycles; wr_index/wr_data hold their last values when wr_en=0.

Optional Feature:
- Macro: PHT_WR_FORWARD_EN.
- Enabled: adds inputs rd_index (INDEX_WIDTH) and outputs fwd_hit (1), fwd_data (COUNTER_WIDTH).
  - Combinational lookup of rd_index against valid buffer slots and the registered wr_* stage.
  - wr_* stage takes precedence: if wr_en && wr_index==rd_index, forward wr_data.
  - Else forward a matching slot.
  - Both outputs are 0 during SWEEP.
- Disabled: ports absent, no compare logic.

Decomposition:
- Shared package pht_pkg:
  - state enum {SWEEP, RUN};
  - buffer slot struct {valid, index, data};
  - DROP_CNT_WIDTH=8.
- One natural sub-module: pht_wbuf, the slot array with allocate/overwrite/invalidate/drain-select logic and the optional forward lookup.
- Top keeps the FSM, sweep counter, arbitration and output registers.

Test Plan:
- Reset, INDEX_WIDTH=4, COUNTER_INIT=1 -> 16 consecutive writes, indices 0..15, data 1; busy=1 for cycles 0..15, 0 after.
- RUN, rb_valid idx 5 data 3 together with co_valid idx 9 data 0 -> cycle+1 writes (5,3); cycle+2 writes (9,0) from buffer.
- Five cycles with rb_valid and co_valid at idx 1..5, BUF_DEPTH=4 -> buf_full after 4; fifth co dropped; drop_cnt=1; buffered writes drain in slot order 1..4.
- Buffer holds idx 7 data 2; co idx 7 data 0 arrives under rb pressure -> no new slot; drained write (7,0). Separately, rb idx 7 -> slot invalidated, (7,2) never written.
- flush_req at sweep_cnt=8 with buffer non-empty -> sweep restarts at index 0; buffer empty; 16 more init writes.
- PHT_WR_FORWARD_EN: slot holds (3,2), rd_index=3 -> fwd_hit=1, fwd_data=2; wr stage (3,1) also valid -> fwd_data=1.
